// File: rtl/cpu_exec_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_exec_unit_if
// Description : Control word, memory bus and status bundle between the 301
//               CPU control unit (master) and the execution datapath (slave).
//               Control inputs : W_Adr, R_Adr, S_Adr, adr_sel, s_sel, pc_ld,
//                                pc_inc, pc_sel, ir_ld, rw_en, alu_op, D_in
//               Datapath outputs: Address, D_out, IR, N, Z, C
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_exec_unit_if;
    logic [2:0]  W_Adr;     // register file write address
    logic [2:0]  R_Adr;     // read port R address
    logic [2:0]  S_Adr;     // read port S address
    logic        adr_sel;   // memory address: 0 = PC, 1 = R port
    logic        s_sel;     // ALU S operand: 0 = S port, 1 = D_in
    logic        pc_ld;     // load PC
    logic        pc_inc;    // increment PC
    logic        pc_sel;    // PC load source: 0 = PC + se(IR[7:0]), 1 = ALU
    logic        ir_ld;     // load IR from D_in
    logic        rw_en;     // register file write enable
    logic [3:0]  alu_op;    // ALU operation
    logic [15:0] D_in;      // memory read data
    logic [15:0] Address;   // memory address
    logic [15:0] D_out;     // memory write data
    logic [15:0] IR;        // instruction register
    logic        N;         // result negative
    logic        Z;         // result zero
    logic        C;         // carry / borrow

    modport master (
        output W_Adr, R_Adr, S_Adr, adr_sel, s_sel, pc_ld, pc_inc, pc_sel,
               ir_ld, rw_en, alu_op, D_in,
        input  Address, D_out, IR, N, Z, C
    );

    modport slave (
        input  W_Adr, R_Adr, S_Adr, adr_sel, s_sel, pc_ld, pc_inc, pc_sel,
               ir_ld, rw_en, alu_op, D_in,
        output Address, D_out, IR, N, Z, C
    );
endinterface
`default_nettype wire

// File: rtl/cpu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : cpu_exec_unit
// Description : 16-bit execution datapath of the 301 CPU. Holds an 8 x 16
//               register file (two read ports, one write port), the ALU, the
//               program counter and the instruction register. Status flags
//               N/Z/C are combinational from the current ALU result; the
//               control unit is responsible for storing them.
// Ports       : clk   - system clock, rising edge
//               reset - synchronous, active-high
//               bus   - cpu_exec_unit_if.slave (control word in, memory
//                       address / write data / IR / status out)
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_exec_unit (
    input  wire logic          clk,
    input  wire logic          reset,
    cpu_exec_unit_if.slave     bus
);

    // ALU operation encoding
    localparam logic [3:0] C_OP_ADD = 4'd0;
    localparam logic [3:0] C_OP_SUB = 4'd1;
    localparam logic [3:0] C_OP_CMP = 4'd2;
    localparam logic [3:0] C_OP_MOV = 4'd3;
    localparam logic [3:0] C_OP_SHL = 4'd4;
    localparam logic [3:0] C_OP_SHR = 4'd5;
    localparam logic [3:0] C_OP_INC = 4'd6;
    localparam logic [3:0] C_OP_DEC = 4'd7;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [15:0] regs_q [8];
    logic [15:0] regs_d [8];
    logic [15:0] pc_q;
    logic [15:0] pc_d;
    logic [15:0] ir_q;
    logic [15:0] ir_d;

    // ------------------------------------------------------------------
    // Datapath wires
    // ------------------------------------------------------------------
    logic [15:0] w_rop;        // R port value
    logic [15:0] w_sreg;       // S port value
    logic [15:0] w_sop;        // ALU S operand after mux
    logic [16:0] w_alu;        // bit 16 carries C for every operation
    logic [15:0] w_y;          // ALU result
    logic [15:0] w_br_off;     // sign-extended IR[7:0]

    // ------------------------------------------------------------------
    // Operand selection (read ports see pre-edge register contents, so a
    // same-address write is only visible after the clock edge)
    // ------------------------------------------------------------------
    always_comb begin
        w_rop  = regs_q[bus.R_Adr];
        w_sreg = regs_q[bus.S_Adr];
        w_sop  = bus.s_sel ? bus.D_in : w_sreg;
    end

    // ------------------------------------------------------------------
    // ALU. Every op produces a 17-bit value whose top bit is C, so the flag
    // logic below does not need to know the opcode. Subtractions are done
    // on zero-extended operands: bit 16 is then exactly the unsigned borrow.
    // CMP is identical to SUB here; it only differs in that the control
    // unit does not assert rw_en.
    // ------------------------------------------------------------------
    always_comb begin
        w_alu = {1'b0, w_sop};
        case (bus.alu_op)
            C_OP_ADD: w_alu = {1'b0, w_rop} + {1'b0, w_sop};
            C_OP_SUB,
            C_OP_CMP: w_alu = {1'b0, w_rop} - {1'b0, w_sop};
            C_OP_MOV: w_alu = {1'b0, w_sop};
            C_OP_SHL: w_alu = {w_sop[15], w_sop[14:0], 1'b0};
            C_OP_SHR: w_alu = {w_sop[0], 1'b0, w_sop[15:1]};
            C_OP_INC: w_alu = {1'b0, w_sop} + 17'd1;
            C_OP_DEC: w_alu = {1'b0, w_sop} - 17'd1;
            default:  w_alu = {1'b0, w_sop};
        endcase
        w_y = w_alu[15:0];
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.N       = w_y[15];
        bus.Z       = (w_y == 16'h0000);
        bus.C       = w_alu[16];
        bus.Address = bus.adr_sel ? w_rop : pc_q;
        bus.D_out   = w_sreg;
        bus.IR      = ir_q;
    end

    // ------------------------------------------------------------------
    // Next-state: register file, PC, IR
    // ------------------------------------------------------------------
    always_comb begin
        w_br_off = {{8{ir_q[7]}}, ir_q[7:0]};

        for (int i = 0; i < 8; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (bus.rw_en) begin
            regs_d[bus.W_Adr] = w_y;
        end

        // pc_ld takes priority over pc_inc
        pc_d = pc_q;
        if (bus.pc_ld) begin
            pc_d = bus.pc_sel ? w_y : (pc_q + w_br_off);
        end else if (bus.pc_inc) begin
            pc_d = pc_q + 16'd1;
        end

        ir_d = bus.ir_ld ? bus.D_in : ir_q;
    end

    // ------------------------------------------------------------------
    // State registers; reset overrides every write enable in its cycle
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= 16'h0000;
            end
            pc_q <= 16'h0000;
            ir_q <= 16'h0000;
        end else begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pc_q <= pc_d;
            ir_q <= ir_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_exec_unit
// Description : Self-checking bench for cpu_exec_unit. Directed scenarios
//               check the documented examples against literal values; a
//               randomized phase checks every output against a behavioural
//               model of the register file, PC and IR.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_exec_unit;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cpu_exec_unit_if bus();

    cpu_exec_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    logic [15:0] m_reg [8];
    logic [15:0] m_pc;
    logic [15:0] m_ir;

    // ALU reference written with plain integer arithmetic
    function automatic void alu_ref(input logic [3:0] op, input logic [15:0] r,
                                    input logic [15:0] s,
                                    output logic [15:0] y, output logic c);
        int unsigned a, b, res;
        a = r; b = s; c = 1'b0;
        case (op)
            4'd0:       begin res = a + b;          c = (res > 65535); end
            4'd1, 4'd2: begin res = a + 65536 - b;  c = (a < b);       end
            4'd3:       res = b;
            4'd4:       begin res = b * 2;          c = (b >= 32768);  end
            4'd5:       begin res = b / 2;          c = (b % 2 == 1);  end
            4'd6:       begin res = b + 1;          c = (b == 65535);  end
            4'd7:       begin res = b + 65535;      c = (b == 0);      end
            default:    res = b;
        endcase
        y = 16'(res % 65536);
    endfunction

    function automatic logic [15:0] sop_ref();
        return bus.s_sel ? bus.D_in : m_reg[bus.S_Adr];
    endfunction

    task automatic clear_ctrl();
        bus.W_Adr = 3'd0; bus.R_Adr = 3'd0; bus.S_Adr = 3'd0;
        bus.adr_sel = 1'b0; bus.s_sel = 1'b0;
        bus.pc_ld = 1'b0; bus.pc_inc = 1'b0; bus.pc_sel = 1'b0;
        bus.ir_ld = 1'b0; bus.rw_en = 1'b0;
        bus.alu_op = 4'd0; bus.D_in = 16'h0000;
        reset = 1'b0;
    endtask

    // One clock edge; the model advances from the same control word.
    task automatic tick();
        logic [15:0] y, npc, nir;
        logic        c;
        logic [15:0] nreg [8];
        int          off;
        alu_ref(bus.alu_op, m_reg[bus.R_Adr], sop_ref(), y, c);
        for (int i = 0; i < 8; i++) nreg[i] = m_reg[i];
        npc = m_pc; nir = m_ir;
        if (reset) begin
            for (int i = 0; i < 8; i++) nreg[i] = 16'h0000;
            npc = 16'h0000; nir = 16'h0000;
        end else begin
            if (bus.rw_en) nreg[bus.W_Adr] = y;
            if (bus.pc_ld) begin
                if (bus.pc_sel) npc = y;
                else begin
                    off = int'(m_ir[7:0]);
                    if (off >= 128) off = off - 256;
                    npc = 16'((int'(m_pc) + off + 65536) % 65536);
                end
            end else if (bus.pc_inc) begin
                npc = 16'((int'(m_pc) + 1) % 65536);
            end
            if (bus.ir_ld) nir = bus.D_in;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) m_reg[i] = nreg[i];
        m_pc = npc; m_ir = nir;
    endtask

    // Stimulus helpers: preload state through the normal datapath
    task automatic load_reg(input logic [2:0] idx, input logic [15:0] val);
        clear_ctrl();
        bus.s_sel = 1'b1; bus.D_in = val; bus.alu_op = 4'd3;
        bus.W_Adr = idx; bus.rw_en = 1'b1;
        tick();
        clear_ctrl();
    endtask

    task automatic load_pc(input logic [15:0] val);
        clear_ctrl();
        bus.s_sel = 1'b1; bus.D_in = val; bus.alu_op = 4'd3;
        bus.pc_ld = 1'b1; bus.pc_sel = 1'b1;
        tick();
        clear_ctrl();
    endtask

    task automatic load_ir(input logic [15:0] val);
        clear_ctrl();
        bus.ir_ld = 1'b1; bus.D_in = val;
        tick();
        clear_ctrl();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        load_reg(3'd3, 16'h1234);
        load_pc(16'h0005);
        load_ir(16'hABCD);
        reset = 1'b1;
        bus.W_Adr = 3'd3; bus.rw_en = 1'b1; bus.pc_inc = 1'b1;
        bus.ir_ld = 1'b1; bus.D_in = 16'h5555; bus.s_sel = 1'b1;
        tick();
        clear_ctrl();
        #1;
        n_tests++;
        if (bus.Address !== 16'h0000) begin
            n_fail++; $display("FAIL reset_pc: got %h expected 0000", bus.Address);
        end
        n_tests++;
        if (bus.IR !== 16'h0000) begin
            n_fail++; $display("FAIL reset_ir: got %h expected 0000", bus.IR);
        end
        for (int i = 0; i < 8; i++) begin
            bus.S_Adr = 3'(i);
            #1;
            n_tests++;
            if (bus.D_out !== 16'h0000) begin
                n_fail++; $display("FAIL reset_r%0d: got %h expected 0000", i, bus.D_out);
            end
        end
        bus.S_Adr = 3'd0;
        #1;
        n_tests++;
        if ({bus.N, bus.Z, bus.C} !== 3'b010) begin
            n_fail++; $display("FAIL reset_flags: got NZC=%b expected 010", {bus.N, bus.Z, bus.C});
        end
    endtask

    task automatic test_add_carry();
        load_reg(3'd1, 16'hFFFF);
        load_reg(3'd2, 16'h0001);
        bus.alu_op = 4'd0; bus.R_Adr = 3'd1; bus.S_Adr = 3'd2;
        bus.W_Adr = 3'd3; bus.rw_en = 1'b1;
        #1;
        n_tests++;
        if ({bus.N, bus.Z, bus.C} !== 3'b011) begin
            n_fail++; $display("FAIL add_flags: got NZC=%b expected 011", {bus.N, bus.Z, bus.C});
        end
        tick();
        clear_ctrl();
        bus.S_Adr = 3'd3;
        #1;
        n_tests++;
        if (bus.D_out !== 16'h0000) begin
            n_fail++; $display("FAIL add_r3: got %h expected 0000", bus.D_out);
        end
    endtask

    task automatic test_sub_cmp();
        load_reg(3'd1, 16'h0003);
        load_reg(3'd2, 16'h0005);
        bus.alu_op = 4'd1; bus.R_Adr = 3'd1; bus.S_Adr = 3'd2;
        bus.W_Adr = 3'd6; bus.rw_en = 1'b1;
        #1;
        n_tests++;
        if ({bus.N, bus.Z, bus.C} !== 3'b101) begin
            n_fail++; $display("FAIL sub_flags: got NZC=%b expected 101", {bus.N, bus.Z, bus.C});
        end
        tick();
        bus.rw_en = 1'b0; bus.S_Adr = 3'd6;
        #1;
        n_tests++;
        if (bus.D_out !== 16'hFFFE) begin
            n_fail++; $display("FAIL sub_y: got %h expected fffe", bus.D_out);
        end
        bus.alu_op = 4'd2; bus.S_Adr = 3'd2; bus.W_Adr = 3'd1;
        #1;
        n_tests++;
        if ({bus.N, bus.Z, bus.C} !== 3'b101) begin
            n_fail++; $display("FAIL cmp_flags: got NZC=%b expected 101", {bus.N, bus.Z, bus.C});
        end
        tick();
        bus.adr_sel = 1'b1;
        #1;
        n_tests++;
        if (bus.Address !== 16'h0003 || bus.D_out !== 16'h0005) begin
            n_fail++; $display("FAIL cmp_nowrite: got R1=%h R2=%h expected 0003 0005", bus.Address, bus.D_out);
        end
        clear_ctrl();
    endtask

    task automatic test_ldi();
        load_pc(16'h0100);
        bus.s_sel = 1'b1; bus.D_in = 16'hBEEF; bus.alu_op = 4'd10;
        bus.W_Adr = 3'd4; bus.rw_en = 1'b1; bus.pc_inc = 1'b1;
        tick();
        clear_ctrl();
        bus.S_Adr = 3'd4;
        #1;
        n_tests++;
        if (bus.D_out !== 16'hBEEF) begin
            n_fail++; $display("FAIL ldi_r4: got %h expected beef", bus.D_out);
        end
        n_tests++;
        if (bus.Address !== 16'h0101) begin
            n_fail++; $display("FAIL ldi_pc: got %h expected 0101", bus.Address);
        end
    endtask

    task automatic test_branch();
        logic [15:0] exp_pc [3];
        exp_pc[0] = 16'hFFFE; exp_pc[1] = 16'hFFFF; exp_pc[2] = 16'h0000;
        load_ir(16'hF8FC);
        load_pc(16'h0002);
        bus.pc_ld = 1'b1; bus.pc_sel = 1'b0; bus.pc_inc = 1'b1;
        tick();
        clear_ctrl();
        #1;
        n_tests++;
        if (bus.Address !== exp_pc[0]) begin
            n_fail++; $display("FAIL branch_pc: got %h expected %h", bus.Address, exp_pc[0]);
        end
        for (int k = 1; k < 3; k++) begin
            bus.pc_inc = 1'b1;
            tick();
            clear_ctrl();
            #1;
            n_tests++;
            if (bus.Address !== exp_pc[k]) begin
                n_fail++; $display("FAIL inc_wrap%0d: got %h expected %h", k, bus.Address, exp_pc[k]);
            end
        end
    endtask

    task automatic test_shift_mem();
        load_reg(3'd5, 16'h8001);
        bus.alu_op = 4'd4; bus.S_Adr = 3'd5; bus.W_Adr = 3'd6; bus.rw_en = 1'b1;
        #1;
        n_tests++;
        if ({bus.N, bus.Z, bus.C} !== 3'b001) begin
            n_fail++; $display("FAIL shl_flags: got NZC=%b expected 001", {bus.N, bus.Z, bus.C});
        end
        tick();
        bus.alu_op = 4'd5; bus.W_Adr = 3'd7;
        #1;
        n_tests++;
        if ({bus.N, bus.Z, bus.C} !== 3'b001) begin
            n_fail++; $display("FAIL shr_flags: got NZC=%b expected 001", {bus.N, bus.Z, bus.C});
        end
        tick();
        clear_ctrl();
        bus.adr_sel = 1'b1; bus.R_Adr = 3'd6; bus.S_Adr = 3'd7;
        #1;
        n_tests++;
        if (bus.Address !== 16'h0002 || bus.D_out !== 16'h4000) begin
            n_fail++; $display("FAIL shift_y: got shl=%h shr=%h expected 0002 4000", bus.Address, bus.D_out);
        end
        bus.R_Adr = 3'd5; bus.S_Adr = 3'd5; bus.s_sel = 1'b1; bus.D_in = 16'h1111;
        #1;
        n_tests++;
        if (bus.Address !== 16'h8001 || bus.D_out !== 16'h8001) begin
            n_fail++; $display("FAIL mem_path: got adr=%h dout=%h expected 8001 8001", bus.Address, bus.D_out);
        end
        clear_ctrl();
    endtask

    task automatic test_rdw_fetch();
        load_reg(3'd2, 16'h0010);
        bus.alu_op = 4'd6; bus.S_Adr = 3'd2; bus.W_Adr = 3'd2; bus.rw_en = 1'b1;
        #1;
        n_tests++;
        if (bus.D_out !== 16'h0010) begin
            n_fail++; $display("FAIL rdw_old: got %h expected 0010", bus.D_out);
        end
        tick();
        bus.rw_en = 1'b0;
        #1;
        n_tests++;
        if (bus.D_out !== 16'h0011) begin
            n_fail++; $display("FAIL rdw_new: got %h expected 0011", bus.D_out);
        end
        clear_ctrl();
        load_pc(16'h0040);
        bus.ir_ld = 1'b1; bus.pc_inc = 1'b1; bus.adr_sel = 1'b0; bus.D_in = 16'h7A31;
        tick();
        clear_ctrl();
        #1;
        n_tests++;
        if (bus.IR !== 16'h7A31 || bus.Address !== 16'h0041) begin
            n_fail++; $display("FAIL fetch: got ir=%h pc=%h expected 7a31 0041", bus.IR, bus.Address);
        end
    endtask

    task automatic test_random();
        logic [15:0] y, exp_adr;
        logic        c;
        for (int n = 0; n < 400; n++) begin
            bus.W_Adr   = 3'($urandom_range(0, 7));
            bus.R_Adr   = 3'($urandom_range(0, 7));
            bus.S_Adr   = 3'($urandom_range(0, 7));
            bus.adr_sel = 1'($urandom);
            bus.s_sel   = 1'($urandom);
            bus.pc_ld   = ($urandom_range(0, 3) == 0);
            bus.pc_inc  = 1'($urandom);
            bus.pc_sel  = 1'($urandom);
            bus.ir_ld   = ($urandom_range(0, 3) == 0);
            bus.rw_en   = 1'($urandom);
            bus.alu_op  = 4'($urandom_range(0, 15));
            // bias D_in toward the carry corner cases
            case ($urandom_range(0, 5))
                0:       bus.D_in = 16'hFFFF;
                1:       bus.D_in = 16'h0000;
                default: bus.D_in = 16'($urandom);
            endcase
            reset = ($urandom_range(0, 39) == 0);
            #1;
            alu_ref(bus.alu_op, m_reg[bus.R_Adr], sop_ref(), y, c);
            exp_adr = bus.adr_sel ? m_reg[bus.R_Adr] : m_pc;
            n_tests++;
            if ({bus.N, bus.Z, bus.C} !== {y[15], (y == 16'h0000), c}) begin
                n_fail++; $display("FAIL rand_flags op=%0d: got NZC=%b expected %b", bus.alu_op,
                                   {bus.N, bus.Z, bus.C}, {y[15], (y == 16'h0000), c});
            end
            n_tests++;
            if (bus.Address !== exp_adr || bus.D_out !== m_reg[bus.S_Adr] || bus.IR !== m_ir) begin
                n_fail++; $display("FAIL rand_state: got adr=%h dout=%h ir=%h expected %h %h %h",
                                   bus.Address, bus.D_out, bus.IR, exp_adr, m_reg[bus.S_Adr], m_ir);
            end
            tick();
        end
        clear_ctrl();
    endtask

    initial begin
        clear_ctrl();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;
        m_pc = 16'h0000; m_ir = 16'h0000;
        tick();
        tick();
        clear_ctrl();
        test_reset();
        test_add_carry();
        test_sub_cmp();
        test_ldi();
        test_branch();
        test_shift_mem();
        test_rdw_fetch();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_exec_unit.md
# cpu_exec_unit

16-bit datapath for the 301 CPU, directly downstream of the control unit. Consumes the control word each cycle and holds the register file, ALU, program counter and instruction register. Feeds IR and combinational N/Z/C status back to the control unit, and drives address and write data to the memory. Flag storage is not in this block; the control unit registers the flags.

## Interface
Parameters
- none (width fixed at 16, 8 registers)

Ports
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising clk
- W_Adr  in  3  register file write address
- R_Adr  in  3  register file read port R address
- S_Adr  in  3  register file read port S address
- adr_sel  in  1  memory address select: 0 = PC, 1 = R port
- s_sel  in  1  ALU S-operand select: 0 = S port, 1 = D_in
- pc_ld  in  1  load PC
- pc_inc  in  1  increment PC
- pc_sel  in  1  PC load source: 0 = PC + sign-extended IR[7:0], 1 = ALU result
- ir_ld  in  1  load IR from D_in
- rw_en  in  1  register file write enable
- alu_op  in  4  ALU operation
- D_in  in  16  memory read data
- Address  out  16  memory address
- D_out  out  16  memory write data (S port value)
- IR  out  16  instruction register
- N, Z, C  out  1 each  combinational status of current ALU result

## Operation
- Register file: R0–R7, 16-bit, all general purpose (R0 not hardwired).
  - Two combinational read ports, R and S.
  - One write port: on the clock edge with rw_en=1, Reg[W_Adr] <= Y.
- Operand muxing:
  - Sop = s_sel ? D_in : Reg[S_Adr]; Rop = Reg[R_Adr].
- ALU result Y, 16-bit; carry C is computed on a 17-bit intermediate:
  - 0 ADD: Rop + Sop; C = carry out.
  - 1 SUB and 2 CMP: Rop − Sop; C = 1 iff Rop < Sop unsigned (borrow).
  - 3 MOV: Sop; C = 0.
  - 4 SHL: Sop << 1, zero fill; C = Sop[15].
  - 5 SHR: Sop >> 1, logical; C = Sop[0].
  - 6 INC: Sop + 1; C = 1 iff Sop = 16'hFFFF.
  - 7 DEC: Sop − 1; C = 1 iff Sop = 0.
  - 8–15: pass Sop; C = 0.
- Flags for every op: N = Y[15]; Z = (Y == 0).
- CMP writes no register only because the CU drops rw_en; the datapath does not special-case it.
- Address = adr_sel ? Rop : PC.
- D_out = Reg[S_Adr], independent of s_sel.
- PC update priority, first match wins:
  1. reset → 0.
  2. pc_ld=1, pc_sel=0 → PC + {{8{IR[7]}}, IR[7:0]}, mod 2^16.
  3. pc_ld=1, pc_sel=1 → Y.
  4. pc_inc=1 → PC + 1, mod 2^16.
  5. Otherwise hold.
- pc_ld wins over pc_inc when both are asserted.
- IR: ir_ld=1 → IR <= D_in; otherwise hold.

## Timing
- Reset, synchronous: on the first rising edge with reset=1, PC, IR and R0–R7 all go to 16'h0000.
  - Outputs one cycle after that edge: Address = 0 (with adr_sel=0), IR = 0, D_out = 0.
  - N/Z/C then follow the combinational inputs; with alu_op=0 and zeroed registers, Z=1, N=0, C=0.
- Reset asserted mid-operation overrides any rw_en, pc_ld, pc_inc or ir_ld in the same cycle; no write occurs.
- Y, N, Z, C, Address and D_out are purely combinational, zero cycles from the control inputs and register state.
- Register, PC and IR writes land one edge after the control word is presented.
- Read-during-write, same address, same cycle: the read ports return the old value; the new value is visible after the edge.
- Fetch, FETCH state (ir_ld=1, pc_inc=1, adr_sel=0):
  - IR captures M[old PC].
  - PC becomes old PC + 1.
  - Both update on the same edge.
- PC wraps: 16'hFFFF + 1 → 16'h0000; 16'h0002 + se(8'hFC) → 16'hFFFE.

## Test plan
- Reset: preload R3 = 16'h1234, PC = 5, assert reset one cycle with rw_en=1 and pc_inc=1 → all registers, PC and IR = 0; no write to W_Adr.
- ADD carry: R1 = 16'hFFFF, R2 = 16'h0001, alu_op=0, R_Adr=1, S_Adr=2, W_Adr=3, rw_en=1 → before the edge Y = 0, Z=1, C=1, N=0; after the edge R3 = 0.
- SUB borrow and CMP: R1 = 3, R2 = 5, alu_op=1 → Y = 16'hFFFE, N=1, C=1, Z=0; same operands with alu_op=2 and rw_en=0 → no register changes.
- LDI path: s_sel=1, D_in = 16'hBEEF, alu_op=10, W_Adr=4, rw_en=1, pc_inc=1 → R4 = 16'hBEEF, PC += 1.
- Branch: IR = 16'hF8FC, PC = 16'h0002, pc_ld=1, pc_sel=0, pc_inc=1 asserted together → PC = 16'hFFFE (load wins). Then pc_inc alone twice → 16'hFFFF, then 16'h0000.
- Shift and memory path: R5 = 16'h8001, SHL with S_Adr=5 → Y = 16'h0002, C=1. SHR → Y = 16'h4000, C=1. adr_sel=1, R_Adr=5 → Address = 16'h8001; D_out tracks Reg[S_Adr] when s_sel=1.
